// File: rtl/fft_pkg.sv
// Shared FFT constants and the bit-reverse helper used by the last butterfly
// stage and by the output reorder buffer.
package fft_pkg;

    localparam int DW        = 16;
    localparam int FFT_N_DEF = 1024;
    localparam int MAX_LOG2N = 16;
    localparam int LOG2N     = $clog2(FFT_N_DEF);

    function automatic int log2n(input int n);
        return $clog2(n);
    endfunction

    // Reverses the low 'bits' bits of k; result lands in the low bits, upper bits zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] k,
                                                    input int bits);
        logic [MAX_LOG2N-1:0] r;
        logic [MAX_LOG2N-1:0] kk;
        r  = '0;
        kk = k;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < bits) begin
                r  = {r[MAX_LOG2N-2:0], kk[0]};
                kk = kk >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module reorder_ram #(
    parameter int DW = 16,
    parameter int AW = 11
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [2*DW-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [2*DW-1:0] rdata
);

    logic [2*DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural-order bins out.
// The writer scatters each frame by bit-reversed address; the reader sweeps linearly.
module fft_reorder #(
    parameter int FFT_N = fft_pkg::FFT_N_DEF,
    parameter int DW    = fft_pkg::DW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic signed [DW-1:0]      in_re,
    input  logic signed [DW-1:0]      in_im,
    output logic                      out_valid,
    output logic signed [DW-1:0]      out_re,
    output logic signed [DW-1:0]      out_im,
    output logic [$clog2(FFT_N)-1:0]  out_index,
    output logic                      out_last,
    output logic                      err_frame
);
    import fft_pkg::*;

    localparam int            AW   = log2n(FFT_N);
    localparam logic [AW-1:0] LAST = AW'(FFT_N - 1);
    localparam logic [0:0]    IDLE = 1'b0;
    localparam logic [0:0]    READ = 1'b1;

    logic [AW-1:0]   wcnt;
    logic [AW-1:0]   wk;
    logic [AW-1:0]   waddr;
    logic            wbank;
    logic            wr_last;
    logic [1:0]      full;

    logic [0:0]      state;
    logic [AW-1:0]   rcnt;
    logic            rbank;
    logic            rd_go;
    logic            rd_last;

    logic            vld_p1;
    logic [AW-1:0]   idx_p1;
    logic [2*DW-1:0] rdata_p1;

    // sof restarts the frame at sample 0 regardless of where the writer was
    assign wk      = in_sof ? '0 : wcnt;
    assign waddr   = AW'(bitrev(MAX_LOG2N'(wk), AW));
    assign wr_last = in_valid && (wk == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt      <= '0;
            wbank     <= 1'b0;
            err_frame <= 1'b0;
        end else if (in_valid) begin
            if (in_sof && (wcnt != '0))
                err_frame <= 1'b1;
            if (wk == LAST) begin
                wcnt  <= '0;
                wbank <= ~wbank;
            end else begin
                wcnt <= wk + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (rd_last)
                full[rbank] <= 1'b0;
            if (wr_last)
                full[wbank] <= 1'b1;
        end
    end

    // Reading starts in the same cycle the full flag is seen, so data is out two cycles after the last write
    assign rd_go   = (state == READ) || ((state == IDLE) && full[rbank]);
    assign rd_last = rd_go && (rcnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= '0;
            rbank <= 1'b0;
        end else if (rd_go) begin
            if (rd_last) begin
                rcnt  <= '0;
                rbank <= ~rbank;
                state <= full[~rbank] ? READ : IDLE;
            end else begin
                rcnt  <= rcnt + 1'b1;
                state <= READ;
            end
        end
    end

    reorder_ram #(
        .DW (DW),
        .AW (AW + 1)
    ) u_ram (
        .clk   (clk),
        .we    (in_valid),
        .waddr ({wbank, waddr}),
        .wdata ({in_re, in_im}),
        .re    (rd_go),
        .raddr ({rbank, rcnt}),
        .rdata (rdata_p1)
    );

    // p1: registered read data, index and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            idx_p1 <= '0;
        end else begin
            vld_p1 <= rd_go;
            if (rd_go)
                idx_p1 <= rcnt;
        end
    end

    assign out_valid = vld_p1;
    assign out_index = idx_p1;
    assign out_last  = vld_p1 && (idx_p1 == LAST);
    assign out_re    = vld_p1 ? rdata_p1[2*DW-1:DW] : '0;
    assign out_im    = vld_p1 ? rdata_p1[DW-1:0]    : '0;

endmodule

// File: tb/tb_fft_reorder.sv
// Bench for fft_reorder: an N=8 and an N=1024 instance checked against a
// frame-level model that permutes each completed frame and predicts output timing.
module tb_fft_reorder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic               iv8 = 1'b0, is8 = 1'b0;
    logic signed [15:0] ir8 = '0, ii8 = '0;
    logic               ov8, ol8, oerr8;
    logic signed [15:0] ore8, oim8;
    logic [2:0]         oidx8;

    logic               iv1k = 1'b0, is1k = 1'b0;
    logic signed [15:0] ir1k = '0, ii1k = '0;
    logic               ov1k, ol1k, oerr1k;
    logic signed [15:0] ore1k, oim1k;
    logic [9:0]         oidx1k;

    always #5 clk = ~clk;

    fft_reorder #(.FFT_N(8), .DW(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_sof(is8), .in_re(ir8), .in_im(ii8),
        .out_valid(ov8), .out_re(ore8), .out_im(oim8), .out_index(oidx8),
        .out_last(ol8), .err_frame(oerr8)
    );

    fft_reorder #(.FFT_N(1024), .DW(16)) dut1k (
        .clk(clk), .rst(rst), .in_valid(iv1k), .in_sof(is1k), .in_re(ir1k), .in_im(ii1k),
        .out_valid(ov1k), .out_re(ore1k), .out_im(oim1k), .out_index(oidx1k),
        .out_last(ol1k), .err_frame(oerr1k)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int nn[2] = '{8, 1024};
    int lg[2] = '{3, 10};

    int cur_re[2][$], cur_im[2][$];
    int exp_re[2][$], exp_im[2][$], exp_idx[2][$], exp_cyc[2][$];
    int got_re[2][$], got_im[2][$];
    bit err_exp[2];
    int outs[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int expv);
        nchk++;
        if (got !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic int bitrev_tb(input int x, input int bits);
        int r = 0;
        repeat (bits) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // Frame-level model: collect samples in arrival order; a full frame emits
    // bin j = sample bitrev(j), starting two cycles after its last sample.
    task automatic model_push(input int d, input bit s, input int re, input int im);
        if (s && cur_re[d].size() != 0) begin
            err_exp[d] = 1'b1;
            cur_re[d].delete();
            cur_im[d].delete();
        end
        cur_re[d].push_back(re);
        cur_im[d].push_back(im);
        if (cur_re[d].size() == nn[d]) begin
            for (int j = 0; j < nn[d]; j++) begin
                int k;
                k = bitrev_tb(j, lg[d]);
                exp_re[d].push_back(cur_re[d][k]);
                exp_im[d].push_back(cur_im[d][k]);
                exp_idx[d].push_back(j);
                exp_cyc[d].push_back(cyc + 2 + j);
            end
            cur_re[d].delete();
            cur_im[d].delete();
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            cur_re[d].delete();  cur_im[d].delete();
            exp_re[d].delete();  exp_im[d].delete();
            exp_idx[d].delete(); exp_cyc[d].delete();
            err_exp[d] = 1'b0;
        end
    endtask

    task automatic drive(input int d, input bit v, input bit s, input int re, input int im);
        @(posedge clk);
        #1;
        iv8 = 1'b0; is8 = 1'b0; iv1k = 1'b0; is1k = 1'b0;
        if (d == 0) begin
            iv8 = v; is8 = s; ir8 = 16'(re); ii8 = 16'(im);
        end else begin
            iv1k = v; is1k = s; ir1k = 16'(re); ii1k = 16'(im);
        end
        if (v)
            model_push(d, s, re, im);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            iv8 = 1'b0; is8 = 1'b0; iv1k = 1'b0; is1k = 1'b0;
        end
    endtask

    task automatic drain(input int d, input int limit);
        int t = 0;
        while (exp_re[d].size() != 0 && t < limit) begin
            idle(1);
            t++;
        end
        chk("drain_timeout", exp_re[d].size(), 0);
        idle(4);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        iv8 = 1'b0; is8 = 1'b0; iv1k = 1'b0; is1k = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid8",  int'(ov8), 0);
        chk("rst_last8",   int'(ol8), 0);
        chk("rst_err8",    int'(oerr8), 0);
        chk("rst_index8",  int'(oidx8), 0);
        chk("rst_re8",     int'(ore8), 0);
        chk("rst_im8",     int'(oim8), 0);
        chk("rst_valid1k", int'(ov1k), 0);
        chk("rst_err1k",   int'(oerr1k), 0);
        chk("rst_index1k", int'(oidx1k), 0);
    endtask

    task automatic mon(input int d, input bit v, input int re, input int im,
                       input int idx, input bit last);
        if (v) begin
            outs[d]++;
            got_re[d].push_back(re);
            got_im[d].push_back(im);
            if (exp_re[d].size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                int er, ei, ex, ec;
                er = exp_re[d].pop_front();
                ei = exp_im[d].pop_front();
                ex = exp_idx[d].pop_front();
                ec = exp_cyc[d].pop_front();
                chk("out_re", re, er);
                chk("out_im", im, ei);
                chk("out_index", idx, ex);
                chk("out_cycle", cyc, ec);
                chk("out_last", int'(last), int'(ex == nn[d] - 1));
            end
        end else begin
            chk("last_when_idle", int'(last), 0);
            if (exp_re[d].size() != 0 && exp_cyc[d][0] <= cyc) begin
                chk("missing_out", 0, 1);
                void'(exp_re[d].pop_front());
                void'(exp_im[d].pop_front());
                void'(exp_idx[d].pop_front());
                void'(exp_cyc[d].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, ov8,  int'(ore8),  int'(oim8),  int'(oidx8),  ol8);
            mon(1, ov1k, int'(ore1k), int'(oim1k), int'(oidx1k), ol1k);
        end
    end

    task automatic check_table8(input string tag);
        int tbl[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        chk({tag, "_count"}, got_re[0].size(), 8);
        for (int i = 0; i < 8 && i < got_re[0].size(); i++) begin
            chk({tag, "_re"}, got_re[0][i], tbl[i]);
            chk({tag, "_im"}, got_im[0][i], -tbl[i]);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        outs[0] = 0;
        outs[1] = 0;
        do_reset();

        // single continuous frame, ramp data
        got_re[0].delete(); got_im[0].delete(); outs[0] = 0;
        for (int i = 0; i < 8; i++) drive(0, 1'b1, i == 0, i, -i);
        drain(0, 100);
        check_table8("ramp");

        // three frames back-to-back
        outs[0] = 0;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++) drive(0, 1'b1, i == 0, f * 8 + i, -(f * 8 + i) - 1);
        drain(0, 100);
        chk("b2b_count", outs[0], 24);

        // gapped input
        got_re[0].delete(); got_im[0].delete(); outs[0] = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, i == 0, i, -i);
            drive(0, 1'b0, 1'b0, 0, 0);
        end
        drain(0, 100);
        check_table8("gapped");

        // truncated frame followed by a full frame
        outs[0] = 0;
        for (int i = 0; i < 5; i++) drive(0, 1'b1, i == 0, 100 + i, 200 + i);
        for (int i = 0; i < 8; i++) drive(0, 1'b1, i == 0, rnd16(), rnd16());
        drain(0, 100);
        chk("partial_count", outs[0], 8);
        chk("err_frame_set", int'(oerr8), int'(err_exp[0]));
        for (int i = 0; i < 8; i++) drive(0, 1'b1, i == 0, rnd16(), rnd16());
        drain(0, 100);
        chk("err_frame_sticky", int'(oerr8), 1);

        // reset during output, reset mid-frame, then a frame starting without sof
        do_reset();
        for (int i = 0; i < 8; i++) drive(0, 1'b1, i == 0, rnd16(), rnd16());
        begin
            int t = 0;
            while (outs[0] < 3 && t < 50) begin
                idle(1);
                t++;
            end
        end
        do_reset();
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b0, rnd16(), rnd16());
        do_reset();
        outs[0] = 0;
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 1'b0, rnd16(), rnd16());
        drain(0, 100);
        chk("after_rst_count", outs[0], 8);

        // random frames with random gaps and optional sof
        outs[0] = 0;
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0) drive(0, 1'b0, 1'b0, 0, 0);
                drive(0, 1'b1, (i == 0) && ($urandom_range(0, 1) == 1), rnd16(), rnd16());
            end
        drain(0, 200);
        chk("rand8_count", outs[0], 48);
        chk("rand8_err", int'(oerr8), 0);

        // N=1024: four random frames
        outs[1] = 0;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 1024; i++)
                drive(1, 1'b1, (i == 0) && ($urandom_range(0, 1) == 1), rnd16(), rnd16());
        drain(1, 3000);
        chk("n1024_count", outs[1], 4096);
        chk("n1024_err", int'(oerr1k), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 The block SHALL have parameter FFT_N, default 1024, meaning the transform length (power of two, 8..65536).
REQ-002 The block SHALL have parameter DW, default 16, meaning the signed sample width per real/imag part.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; every register SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_re/in_im carry a sample this cycle.
REQ-006 The block SHALL have port in_sof, input, 1 bit: qualified by in_valid; marks the first sample of a frame.
REQ-007 The block SHALL have ports in_re and in_im, input, DW bits signed each: last-stage output in bit-reversed order.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_re/out_im/out_index are valid this cycle.
REQ-009 The block SHALL have ports out_re and out_im, output, DW bits signed each: the bin in natural order.
REQ-010 The block SHALL have port out_index, output, log2(FFT_N) bits: the bin number of the current output.
REQ-011 The block SHALL have port out_last, output, 1 bit: high with the bin FFT_N-1.
REQ-012 The block SHALL have port err_frame, output, 1 bit: sticky; a partial frame was discarded.

Function
REQ-013 Two banks of FFT_N entries (ping-pong) SHALL store complex samples; storage width SHALL be 2*DW with no arithmetic and no truncation.
REQ-014 The writer SHALL keep a counter wcnt (log2(FFT_N) bits) and a bank pointer wbank; the k-th valid sample of a frame SHALL be written to address bitrev(k) of bank wbank.
REQ-015 in_valid with in_sof SHALL write at address 0 (bitrev(0)) and set wcnt to 1; if wcnt was nonzero, the partial frame SHALL be discarded and err_frame set.
REQ-016 in_valid without in_sof when wcnt = 0 SHALL be accepted as the frame start.
REQ-017 A write at wcnt = FFT_N-1 SHALL mark bank wbank full, toggle wbank and wrap wcnt to 0.
REQ-018 Gaps (in_valid low) SHALL be allowed anywhere in a frame; they SHALL hold wcnt.
REQ-019 The reader FSM SHALL have two states. IDLE moves to READ when a bank is full. READ moves to IDLE after reading address FFT_N-1, unless the other bank is already full, in which case it continues READ on that bank with no bubble.
REQ-020 In READ, the reader SHALL read address rcnt = 0..FFT_N-1 in consecutive cycles; on the last read, the bank's full flag SHALL clear.
REQ-021 Read data SHALL be registered: out_valid SHALL rise 2 cycles after the cycle holding the frame's last in_valid, and SHALL stay high for exactly FFT_N consecutive cycles per frame.
REQ-022 out_index SHALL equal the read address delayed to align with the data; out_last SHALL equal (out_index = FFT_N-1) AND out_valid.
REQ-023 There SHALL be no backpressure; input at up to 1 sample per cycle SHALL never overwrite an unread bank.
REQ-024 A write and a read in the same cycle (different banks) SHALL both complete.

Reset
REQ-025 Reset SHALL set wcnt, rcnt and wbank to 0, clear both full flags, and put the FSM in IDLE.
REQ-026 Reset SHALL drive out_valid, out_last and err_frame to 0, and out_re, out_im and out_index to 0.
REQ-027 A reset mid-frame SHALL abandon both write and read; the first in_valid after reset SHALL start a new frame at wcnt = 0.
REQ-028 RAM contents SHALL NOT be reset.

Structure
REQ-029 A shared package fft_pkg SHALL hold DW, the default FFT_N, the LOG2N derivation and a bit-reverse function; the last-stage producer SHALL use the same package.
REQ-030 One sub-module, reorder_ram, SHALL be used: a simple dual-port RAM (1 write, 1 registered read) of depth 2*FFT_N, addressed {bank, addr}.

Verification
REQ-031 FFT_N=8: one frame with in_re = 0..7 continuous, in_im = -in_re -> out_re = 0,4,2,6,1,5,3,7 and out_im = the negatives, out_index = 0..7, out_last on the 8th output, first out_valid 2 cycles after the last input.
REQ-032 FFT_N=8: three frames back-to-back with no gaps -> 24 consecutive out_valid cycles with no bubble and correct per-frame ordering.
REQ-033 FFT_N=8: one frame with in_valid toggling 1,0,1,0 -> output identical to REQ-031, delayed, still 8 contiguous cycles.
REQ-034 FFT_N=8: in_sof after 5 samples, then a full frame -> err_frame = 1 sticky, only the full frame is output (8 samples).
REQ-035 FFT_N=8: rst pulsed during output of frame 1 -> out_valid = 0 the next cycle; a following frame is output correctly.
REQ-036 FFT_N=1024: random data, 4 frames -> out_re/out_im equal the bit-reversal permutation of the input; exactly 4096 outputs; err_frame = 0.
